// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one datapath, swept one neuron per clock.
// A tick snapshots the inputs, updates every neuron in turn, then publishes the spike vector.
module lif_neuron_array #(
  parameter int unsigned NUM_NEURONS   = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LEAK_SHIFT    = 2,
  parameter int unsigned REFRACT_TICKS = 3,
  parameter int unsigned SELW          = $clog2(NUM_NEURONS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_NEURONS*WIDTH-1:0] current_in,
  input  logic [WIDTH-1:0]             threshold,
  output logic                         busy,
  output logic                         spike_valid,
  output logic [NUM_NEURONS-1:0]       spikes,
  input  logic [SELW-1:0]              state_sel,
  output logic [WIDTH-1:0]             state_out
);

  localparam int unsigned RW = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic [SELW-1:0] LastIdx = SELW'(NUM_NEURONS - 1);
  localparam logic [RW-1:0] RefractLoad = RW'(REFRACT_TICKS);

  typedef enum logic [1:0] {StIdle, StSweep, StPublish} state_e;

  state_e                       state_q;
  logic [SELW-1:0]              idx_q;
  logic [WIDTH-1:0]             mem_q     [NUM_NEURONS];
  logic [RW-1:0]                refract_q [NUM_NEURONS];
  logic [NUM_NEURONS*WIDTH-1:0] cur_snap_q;
  logic [WIDTH-1:0]             thr_snap_q;
  logic [NUM_NEURONS-1:0]       pending_q;

  logic [WIDTH-1:0]       v_cur;
  logic [WIDTH-1:0]       v_leak;
  logic [WIDTH-1:0]       i_cur;
  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       sum_sat;
  logic [WIDTH-1:0]       mem_new;
  logic [RW-1:0]          ref_cur;
  logic [RW-1:0]          ref_new;
  logic                   fire;
  logic [NUM_NEURONS-1:0] pending_new;

  // Shared update datapath for the neuron currently addressed by idx_q.
  always_comb begin
    v_cur   = mem_q[idx_q];
    ref_cur = refract_q[idx_q];
    i_cur   = cur_snap_q[32'(idx_q) * WIDTH +: WIDTH];
    v_leak  = v_cur - (v_cur >> LEAK_SHIFT);
    sum     = {1'b0, v_leak} + {1'b0, i_cur};
    sum_sat = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    fire    = 1'b0;
    mem_new = '0;
    ref_new = '0;
    if (ref_cur != '0) begin
      ref_new = ref_cur - 1'b1;
    end else if (sum_sat >= thr_snap_q) begin
      fire    = 1'b1;
      ref_new = RefractLoad;
    end else begin
      mem_new = sum_sat;
    end
    pending_new        = pending_q;
    pending_new[idx_q] = fire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cur_snap_q  <= '0;
      thr_snap_q  <= '0;
      pending_q   <= '0;
      busy        <= 1'b0;
      spike_valid <= 1'b0;
      spikes      <= '0;
      state_out   <= '0;
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        mem_q[k]     <= '0;
        refract_q[k] <= '0;
      end
    end else begin
      // Readback reflects the membrane array as it stood before this edge.
      if (32'(state_sel) < NUM_NEURONS) begin
        state_out <= mem_q[state_sel];
      end else begin
        state_out <= '0;
      end
      spike_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            cur_snap_q <= current_in;
            thr_snap_q <= threshold;
            pending_q  <= '0;
            idx_q      <= '0;
            busy       <= 1'b1;
            state_q    <= StSweep;
          end
        end
        StSweep: begin
          mem_q[idx_q]     <= mem_new;
          refract_q[idx_q] <= ref_new;
          pending_q        <= pending_new;
          if (idx_q == LastIdx) begin
            // Spikes land with the last neuron so they are visible during the publish cycle.
            spikes      <= pending_new;
            spike_valid <= 1'b1;
            idx_q       <= '0;
            state_q     <= StPublish;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StPublish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
